// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: word size,
// default geometry/timing and the FSM state encoding.
// DMEM_WAIT_EN adds the WAIT state used for wait-state insertion.
package cpu_mem_pkg;

    localparam int WORD_BITS           = 32;
    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DMEM_WAIT_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    // A request is rejected when it is not word aligned or lands past the
    // last word of storage (full 32-bit comparison, so no aliasing).
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU memory stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
    import cpu_mem_pkg::*;

    logic                 req_valid;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [WORD_BITS-1:0] req_wdata;
    logic                 req_ready;
    logic [WORD_BITS-1:0] d_datain;
    logic                 resp_valid;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, d_datain, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, d_datain, resp_valid, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are deliberately not reset so a reset never loses memory.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH];

    // Write port: commits on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: combinational so a read right after a write sees the new data.
    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: accepts one request at a time, checks it,
// commits writes at acceptance and returns a one-cycle response pulse.
// Optional feature: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states
// between acceptance and response.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                 clock,
    input  logic                 start,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    // Elaboration-time guard on the parameter ranges.
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two in 4..1024");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_t               state_reg;
    logic                 ready_reg;
    logic                 resp_valid_reg;
    logic                 resp_err_reg;
    logic [WORD_BITS-1:0] d_datain_reg;

    logic [AW-1:0]        idx_live;
    logic                 err_live;
    logic                 accept;
    logic                 mem_we;
    logic [AW-1:0]        sel_idx;
    logic                 sel_err;
    logic                 sel_write;
    logic                 issue_resp;
    logic [WORD_BITS-1:0] rdata;

    assign idx_live = bus.req_addr[AW+1:2];
    assign err_live = addr_bad(bus.req_addr, DEPTH);
    assign accept   = bus.req_valid && ready_reg && (state_reg == IDLE);
    assign mem_we   = accept && bus.req_write && !err_live;

`ifdef DMEM_WAIT_EN
    logic [3:0]    wait_cnt_reg;
    logic [AW-1:0] idx_reg;
    logic          err_reg;
    logic          write_reg;

    // While waiting, the captured request drives the array and the response.
    assign sel_idx    = (state_reg == IDLE) ? idx_live       : idx_reg;
    assign sel_err    = (state_reg == IDLE) ? err_live       : err_reg;
    assign sel_write  = (state_reg == IDLE) ? bus.req_write  : write_reg;
    assign issue_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_reg == WAIT) && (wait_cnt_reg <= 4'd1));
`else
    assign sel_idx    = idx_live;
    assign sel_err    = err_live;
    assign sel_write  = bus.req_write;
    assign issue_resp = accept;
`endif

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (sel_idx),
        .wdata (bus.req_wdata),
        .rdata (rdata)
    );

    // FSM with registered outputs; a response is loaded on the edge that enters RESP.
    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            d_datain_reg   <= '0;
`ifdef DMEM_WAIT_EN
            wait_cnt_reg   <= 4'd0;
            idx_reg        <= '0;
            err_reg        <= 1'b0;
            write_reg      <= 1'b0;
`endif
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= !accept;
                    if (accept) begin
`ifdef DMEM_WAIT_EN
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg    <= WAIT;
                            wait_cnt_reg <= 4'(WAIT_CYCLES);
                            idx_reg      <= idx_live;
                            err_reg      <= err_live;
                            write_reg    <= bus.req_write;
                        end
`else
                        state_reg <= RESP;
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                WAIT: begin
                    if (wait_cnt_reg <= 4'd1) begin
                        wait_cnt_reg <= 4'd0;
                        state_reg    <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
`endif
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase

            if (issue_resp) begin
                resp_valid_reg <= 1'b1;
                resp_err_reg   <= sel_err;
                if (!sel_write) begin
                    d_datain_reg <= sel_err ? '0 : rdata;
                end
            end
        end
    end

    assign bus.req_ready  = ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.d_datain   = d_datain_reg;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit words of storage (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted per request when DMEM_WAIT_EN is defined (0..15).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 start  input  1  SHALL be the asynchronous active-low reset (0 = held in reset, 1 = run).
REQ-005 req_valid  input  1  SHALL indicate that the CPU memory stage presents a request.
REQ-006 req_write  input  1  SHALL select a write (1) or a read (0).
REQ-007 req_addr  input  32  SHALL carry the byte address.
REQ-008 req_wdata  input  32  SHALL carry the CPU store data (the CPU's d_dataout).
REQ-009 req_ready  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-010 d_datain  output  32  SHALL return read data to the CPU.
REQ-011 resp_valid  output  1  SHALL pulse for one cycle when a request completes.
REQ-012 resp_err  output  1  SHALL flag a misaligned or out-of-range request, qualified by resp_valid.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_* SHALL be captured at that edge.
REQ-015 The word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-016 Misaligned (req_addr[1:0]!=0) or out-of-range (req_addr>>2 >= DEPTH) requests SHALL set resp_err, SHALL NOT write, and SHALL return 0 on reads.
REQ-017 A valid write SHALL update storage at the acceptance edge.
REQ-018 Without wait states, the FSM SHALL go IDLE->RESP at acceptance, assert resp_valid in the following cycle, then return to IDLE (one-cycle latency, one accepted request every two cycles).
REQ-019 d_datain SHALL update only when a read response is issued, and SHALL otherwise hold its last value.
REQ-020 A read issued right after a write to the same word SHALL return the newly written data.
REQ-021 req_valid in a non-IDLE state SHALL be ignored; the CPU holds the request until it is accepted.

Reset
REQ-022 While start=0: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, d_datain=0, wait counter=0.
REQ-023 Asserting start low mid-request SHALL abandon the request with no response; a write already committed at acceptance SHALL remain.
REQ-024 Storage contents SHALL NOT be reset.
REQ-025 req_ready SHALL rise in the first cycle after start deasserts (goes high).

Configuration
REQ-026 With DMEM_WAIT_EN defined, acceptance SHALL go IDLE->WAIT, load a counter with WAIT_CYCLES, decrement it each cycle, and go to RESP when it reaches 0 (latency WAIT_CYCLES+1); WAIT_CYCLES=0 SHALL go directly to RESP.
REQ-027 Without DMEM_WAIT_EN, the WAIT state and counter SHALL be absent, and the behaviour SHALL be that of REQ-018.

Structure
REQ-028 The package cpu_mem_pkg SHALL hold the FSM state encoding, the DEPTH and WAIT_CYCLES defaults and the word-size constant.
REQ-029 Storage SHALL be a sub-module dmem_array (single port, synchronous write, combinational read); the FSM, error check and output registers SHALL live in data_mem_responder.

Verification
REQ-030 Write 0x000000ab to addr 0x4, then read addr 0x4 -> resp_valid one cycle after acceptance (no macro), d_datain=0x000000ab, resp_err=0.
REQ-031 Write 0x00003c00 to addr 0x8, then read 0x4 and 0x8 back to back -> 0x000000ab then 0x00003c00; req_ready=0 in each RESP cycle.
REQ-032 Read addr 0x6 and read addr DEPTH*4 -> resp_err=1, d_datain=0; a later read of 0x4 is unchanged.
REQ-033 With DMEM_WAIT_EN and WAIT_CYCLES=2, read 0x4 -> resp_valid exactly 3 cycles after acceptance; req_valid held meanwhile is not accepted.
REQ-034 Pull start low during WAIT -> no resp_valid, outputs at reset values; after release, read 0x4 returns 0x000000ab.
